// File: rtl/smc_lite_pkg.sv
// Shared types and helpers for the static memory controller external-bus sequencer.
// Holds the FSM state encoding, the access size codes and the beat-count arithmetic.
package smc_lite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } smc_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Size code 3 is reserved and behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] nb;
        case (size)
            SZ_BYTE: nb = 3'd1;
            SZ_HALF: nb = 3'd2;
            default: nb = 3'd4;
        endcase
        return nb;
    endfunction

    function automatic logic [2:0] beat_count(input logic [1:0] size, input int ext_bytes);
        int n;
        n = int'(size_bytes(size)) / ext_bytes;
        return (n < 1) ? 3'd1 : 3'(n);
    endfunction

endpackage

// File: rtl/smc_lane_steer.sv
// Combinational byte-lane steering between the 32-bit word lane image and the external bus.
// Zero latency; no flow control, pure mapping of enables, write data and read-data merge.
module smc_lane_steer #(
    parameter int EXT_DW = 16
) (
    input  logic [1:0]          acc_ofs_i,
    input  logic [2:0]          acc_bytes_i,
    input  logic [1:0]          wr_ofs_i,
    input  logic [31:0]         wr_word_i,
    output logic [EXT_DW/8-1:0] wr_be_n_o,
    output logic [EXT_DW-1:0]   wr_dat_o,
    input  logic [1:0]          rd_ofs_i,
    input  logic [EXT_DW/8-1:0] rd_be_n_i,
    input  logic [EXT_DW-1:0]   rd_dat_i,
    input  logic [31:0]         rd_word_i,
    output logic [31:0]         rd_word_o
);

    function automatic logic [1:0] lane_of(input logic [1:0] ofs, input int j);
        logic [1:0] jl;
        jl = j[1:0];
        return ofs + jl;
    endfunction

    function automatic logic lane_hit(input logic [1:0] lane, input logic [1:0] ofs,
                                      input logic [2:0] nbytes);
        logic [2:0] l;
        logic [2:0] lo;
        l  = {1'b0, lane};
        lo = {1'b0, ofs};
        return (l >= lo) && (l < lo + nbytes);
    endfunction

    always_comb begin
        wr_be_n_o = '1;
        wr_dat_o  = '0;
        rd_word_o = rd_word_i;
        for (int j = 0; j < EXT_DW / 8; j++) begin
            wr_be_n_o[j]       = ~lane_hit(lane_of(wr_ofs_i, j), acc_ofs_i, acc_bytes_i);
            wr_dat_o[8*j +: 8] = wr_word_i[{lane_of(wr_ofs_i, j), 3'b000} +: 8];
            if (!rd_be_n_i[j])
                rd_word_o[{lane_of(rd_ofs_i, j), 3'b000} +: 8] = rd_dat_i[8*j +: 8];
        end
    end

endmodule

// File: rtl/smc_mac_lite.sv
// External-bus sequencer: splits one AHB access into EXT_DW beats of SETUP, STROBE(ws+1), HOLD.
// Each beat takes ws+3 cycles; a new access is only taken in IDLE or in the final HOLD.
module smc_mac_lite
    import smc_lite_pkg::*;
#(
    parameter int EXT_DW = 16,
    parameter int WS_W   = 4
) (
    input  logic                hclk,
    input  logic                sys_reset,
    input  logic                new_access,
    input  logic                cs,
    input  logic [31:0]         addr,
    input  logic [1:0]          xfer_size,
    input  logic                n_read,
    input  logic [31:0]         write_data,
    input  logic [WS_W-1:0]     cfg_ws_rd,
    input  logic [WS_W-1:0]     cfg_ws_wr,
    input  logic [EXT_DW-1:0]   ext_data_in,
    output logic                smc_idle,
    output logic                smc_done,
    output logic                mac_done,
    output logic [31:0]         read_data,
    output logic [31:0]         ext_addr,
    output logic [EXT_DW-1:0]   ext_data_out,
    output logic                ext_data_oe,
    output logic                n_ext_cs,
    output logic                n_ext_oe,
    output logic                n_ext_we,
    output logic [EXT_DW/8-1:0] n_ext_be
);

    localparam int          EXT_BYTES  = EXT_DW / 8;
    localparam int          BEAT_SH    = $clog2(EXT_BYTES);
    localparam logic [31:0] ALIGN_MASK = ~(32'(EXT_BYTES) - 32'd1);

    smc_state_e           state_q;
    logic [1:0]           beat_q, beat_d;
    logic [WS_W-1:0]      wait_q, ws_q, ws_d;
    logic [31:0]          addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]           size_q, size_d;
    logic                 n_read_q, n_read_d;
    logic [2:0]           acc_bytes_d;
    logic [31:0]          read_data_q, rd_merged;
    logic [31:0]          ext_addr_q, ext_addr_d;
    logic [EXT_DW-1:0]    ext_data_out_q, wdat_d;
    logic [EXT_BYTES-1:0] n_ext_be_q, be_n_d;
    logic                 ext_data_oe_q, n_ext_cs_q, n_ext_oe_q, n_ext_we_q;
    logic                 last_beat, accept, enter_setup;

    assign last_beat   = ({1'b0, beat_q} == beat_count(size_q, EXT_BYTES) - 3'd1);
    assign accept      = new_access & cs &
                         ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & last_beat));
    assign enter_setup = accept | ((state_q == ST_HOLD) & ~last_beat);

    // Context of the beat that starts at this edge, so the bus outputs can be registered.
    always_comb begin
        addr_d      = accept ? addr : addr_q;
        size_d      = accept ? xfer_size : size_q;
        n_read_d    = accept ? n_read : n_read_q;
        wdata_d     = accept ? write_data : wdata_q;
        ws_d        = accept ? (n_read ? cfg_ws_wr : cfg_ws_rd) : ws_q;
        acc_bytes_d = size_bytes(size_d);
        beat_d      = beat_q;
        if (accept)
            beat_d = '0;
        else if ((state_q == ST_HOLD) && !last_beat)
            beat_d = beat_q + 2'd1;
        ext_addr_d  = (addr_d & ALIGN_MASK) + (32'(beat_d) << BEAT_SH);
    end

    smc_lane_steer #(.EXT_DW(EXT_DW)) u_steer (
        .acc_ofs_i   (addr_d[1:0]),
        .acc_bytes_i (acc_bytes_d),
        .wr_ofs_i    (ext_addr_d[1:0]),
        .wr_word_i   (wdata_d),
        .wr_be_n_o   (be_n_d),
        .wr_dat_o    (wdat_d),
        .rd_ofs_i    (ext_addr_q[1:0]),
        .rd_be_n_i   (n_ext_be_q),
        .rd_dat_i    (ext_data_in),
        .rd_word_i   (read_data_q),
        .rd_word_o   (rd_merged)
    );

    always_ff @(posedge hclk) begin
        if (sys_reset) begin
            state_q        <= ST_IDLE;
            beat_q         <= '0;
            wait_q         <= '0;
            ws_q           <= '0;
            addr_q         <= '0;
            size_q         <= SZ_BYTE;
            n_read_q       <= 1'b0;
            wdata_q        <= '0;
            read_data_q    <= '0;
            ext_addr_q     <= '0;
            ext_data_out_q <= '0;
            n_ext_be_q     <= '1;
            ext_data_oe_q  <= 1'b0;
            n_ext_cs_q     <= 1'b1;
            n_ext_oe_q     <= 1'b1;
            n_ext_we_q     <= 1'b1;
        end else begin
            if ((state_q == ST_STROBE) && (wait_q == '0) && !n_read_q)
                read_data_q <= rd_merged;
            if (enter_setup) begin
                state_q        <= ST_SETUP;
                addr_q         <= addr_d;
                size_q         <= size_d;
                n_read_q       <= n_read_d;
                wdata_q        <= wdata_d;
                ws_q           <= ws_d;
                beat_q         <= beat_d;
                ext_addr_q     <= ext_addr_d;
                ext_data_out_q <= wdat_d;
                n_ext_be_q     <= be_n_d;
                ext_data_oe_q  <= n_read_d;
                n_ext_cs_q     <= 1'b0;
                n_ext_oe_q     <= 1'b1;
                n_ext_we_q     <= 1'b1;
            end else begin
                case (state_q)
                    ST_SETUP: begin
                        state_q    <= ST_STROBE;
                        wait_q     <= ws_q;
                        n_ext_oe_q <= n_read_q;
                        n_ext_we_q <= ~n_read_q;
                    end
                    ST_STROBE: begin
                        if (wait_q == '0) begin
                            state_q    <= ST_HOLD;
                            n_ext_oe_q <= 1'b1;
                            n_ext_we_q <= 1'b1;
                        end else begin
                            wait_q <= wait_q - WS_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        state_q       <= ST_IDLE;
                        n_ext_cs_q    <= 1'b1;
                        ext_data_oe_q <= 1'b0;
                        n_ext_be_q    <= '1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign smc_idle     = (state_q == ST_IDLE);
    assign smc_done     = (state_q == ST_HOLD);
    assign mac_done     = (state_q != ST_IDLE) & last_beat;
    assign read_data    = read_data_q;
    assign ext_addr     = ext_addr_q;
    assign ext_data_out = ext_data_out_q;
    assign ext_data_oe  = ext_data_oe_q;
    assign n_ext_cs     = n_ext_cs_q;
    assign n_ext_oe     = n_ext_oe_q;
    assign n_ext_we     = n_ext_we_q;
    assign n_ext_be     = n_ext_be_q;

endmodule

// File: doc/smc_mac_lite.md
# smc_mac_lite

External-bus sequencer for the static memory controller. Sits directly downstream of the AHB-lite interface stage: it accepts one validated AHB access, splits it into one or more external-bus beats of width `EXT_DW`, and drives chip select, strobes, address and data with programmable wait states. It returns `smc_done`, `mac_done`, `smc_idle` and the assembled `read_data` to the interface stage, which forms `smc_hready` from them.

## Interface
- `EXT_DW`, 16, external data width in bits; legal values 8, 16, 32. `EXT_BYTES = EXT_DW/8`.
- `WS_W`, 4, width of the wait-state config fields.

- `hclk` in 1: the single clock.
- `sys_reset` in 1: reset, **synchronous, active-high**.
- `new_access` in 1: a valid AHB access is presented this cycle.
- `cs` in 1: bank select; an access is accepted only if `new_access & cs`.
- `addr` in 32: byte address of the access.
- `xfer_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `n_read` in 1: 0 = read, 1 = write.
- `write_data` in 32: AHB write data, in word lane image.
- `cfg_ws_rd` in `WS_W`: read wait states.
- `cfg_ws_wr` in `WS_W`: write wait states.
- `ext_data_in` in `EXT_DW`: external read data.
- `smc_idle` out 1: FSM is in IDLE.
- `smc_done` out 1: last cycle (HOLD) of every beat.
- `mac_done` out 1: high for the entire final beat of an access.
- `read_data` out 32: assembled read data, in word lane image.
- `ext_addr` out 32: beat address, aligned to `EXT_BYTES`.
- `ext_data_out` out `EXT_DW`: write data for the beat.
- `ext_data_oe` out 1: data output enable; high in SETUP/STROBE/HOLD of write beats.
- `n_ext_cs` out 1: active-low chip select.
- `n_ext_oe` out 1: active-low output enable.
- `n_ext_we` out 1: active-low write enable.
- `n_ext_be` out `EXT_BYTES`: active-low byte lane enables.

## Operation
- **FSM states:** IDLE, SETUP, STROBE, HOLD.
- **Accept:** in IDLE, or in HOLD of the final beat, `new_access & cs` latches `addr`, `xfer_size`, `n_read`, `write_data`, and the applicable wait-state field (`cfg_ws_rd` or `cfg_ws_wr`). The FSM then moves to SETUP. `new_access` in any other state is ignored; the upstream stage holds hready low, so it cannot legally occur.
- **Beat count:** `bytes = 1 << min(xfer_size,2)`; `N = max(1, bytes/EXT_BYTES)`. The beat counter is `beat`, from 0 to N-1.
- **Beat address:** `ext_addr = (addr & ~(EXT_BYTES-1)) + beat*EXT_BYTES`. The upstream stage guarantees alignment.
- **Lane mapping:** external lane j maps to word lane `ext_addr[1:0]+j`.
  - `n_ext_be[j]` is low only if that word lane lies within `[addr[1:0], addr[1:0]+bytes)`.
  - `ext_data_out` lane j = `write_data` word lane `ext_addr[1:0]+j`.
- **SETUP (1 cycle):** `n_ext_cs`=0, address and byte enables valid, strobes high.
- **STROBE (ws+1 cycles):** `n_ext_oe`=0 for reads, `n_ext_we`=0 for writes. A down-counter, loaded with ws on SETUP exit, counts the cycles.
- **Read capture:** on the last STROBE cycle, every enabled lane j of `ext_data_in` is written into `read_data` word lane `ext_addr[1:0]+j`. Lanes that are not enabled keep their value.
- **HOLD (1 cycle):** strobes high, `n_ext_cs`=0, `smc_done`=1. Then:
  - if `beat<N-1`: increment `beat`, go to SETUP.
  - else if a new access is accepted: go to SETUP.
  - else: go to IDLE.
- **`mac_done`:** high whenever `beat==N-1` and the state is not IDLE. Therefore `smc_done & mac_done` is high only in the final HOLD cycle.
- **Reset values:** state IDLE, `smc_idle`=1, `smc_done`=0, `mac_done`=0, `read_data`=0, `ext_addr`=0, `ext_data_out`=0, `ext_data_oe`=0, `n_ext_cs`=1, `n_ext_oe`=1, `n_ext_we`=1, `n_ext_be`=all 1s, beat and wait counters 0.
- **Reset mid-access:** `sys_reset` at any state aborts the access. All outputs take their reset values on the next edge, and no `smc_done` is issued.

## Timing
- All external outputs are registered.
- `smc_done`, `mac_done` and `smc_idle` are decoded from registered state; `read_data` is a register.
- Per-beat length is `ws+3` cycles.
- If the accept occurs at edge 0, SETUP is the state during cycle 1. The final HOLD occupies cycle `N*(ws+3)`.
- `read_data` is stable throughout the final HOLD cycle, which is the cycle upstream samples it.
- **Back-to-back accesses:** accept in the final HOLD, then SETUP of the new access immediately follows. There is no IDLE cycle and `smc_idle` stays 0.
- Wait states are sampled once per access, at accept. Config changes mid-access have no effect.

## Structure
- Shared package `smc_lite_pkg`:
  - state encoding enum (IDLE, SETUP, STROBE, HOLD);
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD;
  - a function computing the beat count N from size and `EXT_BYTES`.
- One natural sub-module, `smc_lane_steer`: combinational lane and byte-enable mapping for both write and read directions, parameterised by `EXT_DW`.
- FSM, counters and capture registers live in the top module.

## Test plan
- **16-bit word write, ws=0:** `EXT_DW`=16, write of 0xAABBCCDD to 0x100 with `cfg_ws_wr`=0.
  - Response: 2 beats of 3 cycles each.
  - Beat 0: `ext_addr` 0x100, data 0xCCDD. Beat 1: `ext_addr` 0x102, data 0xAABB.
  - `n_ext_we` low for 1 cycle per beat; `smc_done&mac_done` only in cycle 6.
- **16-bit byte read, ws=2:** read of byte 0x103 with `cfg_ws_rd`=2.
  - Response: one beat of 5 cycles; `ext_addr` 0x102, `n_ext_be`=2'b01.
  - With `ext_data_in`=0x5A00, `read_data[31:24]`=0x5A and the other lanes unchanged.
- **8-bit word read:** `EXT_DW`=8, word read at 0x200 with ws=1.
  - Response: 4 beats at 0x200–0x203, total 16 cycles.
  - `read_data` is assembled little-endian; `mac_done` is high only during beat 3.
- **Back-to-back:** `new_access` held during the final HOLD.
  - Response: next cycle is SETUP with the new address; `smc_idle` never asserts between the accesses.
- **Reset mid-access:** `sys_reset` asserted during STROBE of beat 1.
  - Response: next cycle shows IDLE, all strobes and `n_ext_cs` high, `read_data`=0, and no `smc_done`.
- **Ignored / reserved accesses:**
  - `new_access`=1 with `cs`=0 in IDLE: no state change.
  - `xfer_size`=3 on `EXT_DW`=32: single beat, `n_ext_be`=4'b0000.
